// File: rtl/sub_serial_32bit.sv
// sub_serial_32bit: multi-cycle 32-bit subtractor, in1 - in2 - bin.
// One SLICE-bit chunk is processed per clock, LSB chunk first, through a
// single narrow borrow chain. Results are held until the next operation
// completes.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one slice per edge, slice counter k walks 0 .. N-1
// DONE  | results just loaded, done pulses for this single cycle
module sub_serial_32bit #(
    parameter int SLICE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero
);

    localparam int N  = 32 / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [31:0]   a_reg;     // minuend
    logic [31:0]   bn_reg;    // inverted subtrahend; sign of in2 is ~bn_reg[31]
    logic [31:0]   res_reg;   // result slices assembled so far
    logic          c_reg;     // internal carry, i.e. inverted borrow
    logic [CW-1:0] k;
    logic [SLICE:0] s;
    logic [31:0]   res_next;

    // One slice of a + ~b + c, and the result word with that slice inserted
    always_comb begin
        s = {1'b0, a_reg[int'(k) * SLICE +: SLICE]}
          + {1'b0, bn_reg[int'(k) * SLICE +: SLICE]}
          + {{SLICE{1'b0}}, c_reg};
        res_next = res_reg;
        res_next[int'(k) * SLICE +: SLICE] = s[SLICE-1:0];
    end

    // Sequencer, working registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            bn_reg  <= '0;
            res_reg <= '0;
            c_reg   <= 1'b0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= in1;
                        bn_reg <= ~in2;
                        c_reg  <= ~bin;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_reg <= res_next;
                    c_reg   <= s[SLICE];
                    if (k == K_LAST) begin
                        // Flags use the operand signs, so ovf sees bin only via diff[31]
                        diff  <= res_next;
                        bout  <= ~s[SLICE];
                        ovf   <= (a_reg[31] != ~bn_reg[31]) & (res_next[31] != a_reg[31]);
                        zero  <= (res_next == '0);
                        done  <= 1'b1;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_serial_32bit.md
# sub_serial_32bit

Multi-cycle 32-bit two's-complement subtractor, the subtract-direction counterpart of the combinational ripple-carry adder chain. It computes in1 − in2 − bin one SLICE-bit chunk per clock, LSB chunk first, through a single narrow borrow chain. It trades latency for area in datapaths that need subtraction, compare or borrow without a second full-width carry chain. Operands are taken on a start/busy/done handshake, and results are held until the next operation completes.

## Interface
- SLICE, default 4: bits processed per cycle. Legal values are 1, 2, 4, 8, 16 and 32. N = 32/SLICE cycles per operation.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset. Reset is asynchronous and active-low, on one clock.
- start  in  1  request; sampled only in IDLE.
- in1  in  32  minuend, captured on the accepting edge.
- in2  in  32  subtrahend, captured on the accepting edge.
- bin  in  1  borrow-in, captured on the accepting edge.
- busy  out  1  high while state is RUN or DONE.
- done  out  1  one-cycle pulse; results valid and updated.
- diff  out  32  (in1 − in2 − bin) mod 2^32.
- bout  out  1  borrow-out: 1 iff unsigned in1 < in2 + bin.
- ovf  out  1  signed overflow of the subtraction.
- zero  out  1  diff == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN when start=1 at the edge. On that edge:
  - latch in1, in2 and ~in2 into working registers;
  - slice counter k=0;
  - internal carry c = ~bin.
- RUN, each edge:
  - s = a[k] + ~b[k] + c (SLICE+1 bits);
  - result slice k = s[SLICE−1:0]; c = s[SLICE];
  - k increments.
- After slice N−1 is processed, go to DONE. On that edge also load:
  - diff from the assembled result;
  - bout = ~c_final;
  - ovf = (in1[31] ≠ in2[31]) & (diff[31] ≠ in1[31]);
  - zero = (diff == 0).
- DONE→IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; the operation in progress is never disturbed. start held high continuously gives back-to-back operations every N+2 cycles.
- Operands are captured, so in1, in2 and bin may change freely after the accepting edge.
- diff, bout, ovf and zero change only on the edge entering DONE. Otherwise they hold the last result.
- Width rules:
  - all arithmetic is modulo 2^32;
  - bin=1 with in1 == in2 gives diff=0xFFFFFFFF and bout=1;
  - bout is independent of the signed interpretation;
  - ovf is independent of bin except through diff[31].

## Timing
- Reset values: state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, zero=0. Counter and working registers are also cleared.
- rst_n low at any time, including mid-RUN, forces the reset values immediately. The operation is aborted and no done pulse follows.
- Latency: start accepted at edge E0 → done high in the cycle after edge EN. That is N cycles: 8 for SLICE=4, 32 for SLICE=1, 1 for SLICE=32.
- busy rises in the cycle after E0 and falls in the cycle after E(N+1).
- done is exactly one cycle wide, coincident with the last busy cycle.
- Earliest next accept is at edge E(N+2) (state IDLE).
- Critical path is one SLICE-bit ripple plus the counter. No full-width chain except the zero detect on the loaded result.

## Test plan
- Basic subtract, SLICE=4: in1=5, in2=3, bin=0. Required: diff=2, bout=0, ovf=0, zero=0, with done exactly 8 cycles after the accepting edge.
- Unsigned borrow: in1=3, in2=5, bin=0. Required: diff=0xFFFFFFFE, bout=1, ovf=0.
- Signed overflow: in1=0x80000000, in2=1. Required: diff=0x7FFFFFFF, ovf=1, bout=0.
- Borrow-in edge case: in1=in2=0x1234ABCD, bin=1. Required: diff=0xFFFFFFFF, bout=1, zero=0. The same case with bin=0 gives diff=0 and zero=1.
- Handshake under load: hold start=1 with new operands every cycle. Required:
  - results reflect only the operands at each IDLE accept;
  - the done period is N+2 cycles;
  - outputs are stable between done pulses.
- Reset mid-operation: assert rst_n=0 in RUN at k=3. Required: all outputs are 0 immediately and no done pulse appears. A subsequent 0−0 then completes normally with zero=1.
- Parameter sweep: rerun the scenarios with SLICE=1 and SLICE=32. Required: latency is 32 and 1 cycles respectively, with identical results.
